// File: rtl/pwm_duty_if.sv
// Button/period inputs and duty command outputs shared by the duty controller and its driver.
interface pwm_duty_if;
  logic       increase_duty;
  logic       decrease_duty;
  logic       period_end;
  logic [3:0] duty_cmd;
  logic       duty_load;
  logic       duty_pending;
  logic       sat_flag;

  modport master (
    output increase_duty, decrease_duty, period_end,
    input  duty_cmd, duty_load, duty_pending, sat_flag
  );

  modport slave (
    input  increase_duty, decrease_duty, period_end,
    output duty_cmd, duty_load, duty_pending, sat_flag
  );
endinterface

// File: rtl/pwm_duty_ctrl.sv
// Debounced up/down buttons adjust a duty target that is applied to the PWM only at period ends.
// Optional macro PWM_DUTY_CTRL_AUTOREPEAT_EN adds auto-repeat while a button stays held.
module pwm_duty_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DUTY_MAX        = 10,
  parameter int unsigned DUTY_INIT       = 5,
  parameter int unsigned REPEAT_CYCLES   = 50
) (
  input  logic      clk,
  input  logic      rst_n,
  pwm_duty_if.slave bus
);

  localparam int unsigned DUTY_W = 4;
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PENDING, LOAD} state_t;

  // index 0 = increase, index 1 = decrease
  logic [1:0]        raw, sync1, sync2, level, level_d, evt_c;
  logic [DB_W-1:0]   db_cnt [2];

  state_t            state;
  logic [DUTY_W-1:0] target, target_nxt, duty_cmd, duty_cmd_nxt;
  logic              duty_load, duty_pending, sat_flag, sat_c;

  assign raw = {bus.decrease_duty, bus.increase_duty};

  // Synchronize, then accept a level only after it is stable for DEBOUNCE_CYCLES samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

`ifdef PWM_DUTY_CTRL_AUTOREPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES + 1);

  logic [RPT_W-1:0] rpt_cnt [2];
  logic [1:0]       rpt_fire_c;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rpt_fire_c[i] = level[i] & level_d[i] & (rpt_cnt[i] == RPT_W'(REPEAT_CYCLES - 1));
    end
  end

  // Interval counter restarts on every event so repeats land REPEAT_CYCLES apart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) rpt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!level[i] || evt_c[i]) rpt_cnt[i] <= '0;
        else                       rpt_cnt[i] <= rpt_cnt[i] + RPT_W'(1);
      end
    end
  end

  assign evt_c = (level & ~level_d) | rpt_fire_c;
`else
  assign evt_c = level & ~level_d;
`endif

  // Target update with saturation; simultaneous up/down cancels silently
  always_comb begin
    target_nxt = target;
    sat_c      = 1'b0;
    case (evt_c)
      2'b01: begin
        if (target == DUTY_W'(DUTY_MAX)) sat_c = 1'b1;
        else                             target_nxt = target + DUTY_W'(1);
      end
      2'b10: begin
        if (target == '0) sat_c = 1'b1;
        else              target_nxt = target - DUTY_W'(1);
      end
      default: ;
    endcase
    duty_cmd_nxt = (state == PENDING && bus.period_end) ? target : duty_cmd;
  end

  // duty_cmd loads the pre-edge target so an event on period_end waits one more period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      target       <= DUTY_W'(DUTY_INIT);
      duty_cmd     <= DUTY_W'(DUTY_INIT);
      duty_load    <= 1'b0;
      duty_pending <= 1'b0;
      sat_flag     <= 1'b0;
    end else begin
      target       <= target_nxt;
      duty_cmd     <= duty_cmd_nxt;
      duty_load    <= (state == PENDING) && bus.period_end;
      duty_pending <= (target_nxt != duty_cmd_nxt);
      sat_flag     <= sat_c;
      case (state)
        IDLE:    if (target_nxt != duty_cmd) state <= PENDING;
        PENDING: if (bus.period_end)         state <= LOAD;
        LOAD:    state <= (target_nxt != duty_cmd) ? PENDING : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.duty_cmd     = duty_cmd;
  assign bus.duty_load    = duty_load;
  assign bus.duty_pending = duty_pending;
  assign bus.sat_flag     = sat_flag;

endmodule

// File: doc/pwm_duty_ctrl.md
PWM_DUTY_CTRL -- requirements
Module: pwm_duty_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples before a button level is accepted.
REQ-002 Parameter DUTY_MAX, default 10: maximum duty step count (10 steps = 100%).
REQ-003 Parameter DUTY_INIT, default 5: duty step count loaded at reset.
REQ-004 Parameter REPEAT_CYCLES, default 50: auto-repeat interval in clocks (used only with REQ-030).
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 increase_duty  input  1  raw asynchronous button, active-high.
REQ-008 decrease_duty  input  1  raw asynchronous button, active-high.
REQ-009 period_end  input  1  one-cycle pulse from PWM generator on last cycle of each PWM period.
REQ-010 duty_cmd  output  4  duty step count applied to PWM generator.
REQ-011 duty_load  output  1  one-cycle strobe; duty_cmd changed this cycle.
REQ-012 duty_pending  output  1  high while target differs from duty_cmd.
REQ-013 sat_flag  output  1  one-cycle pulse when a request is rejected at a limit.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 Per button, a debounce counter SHALL accept a new level only after the synchronized input holds that level for DEBOUNCE_CYCLES consecutive cycles; any toggle restarts the count.
REQ-016 A request event SHALL be generated for one cycle on each 0->1 transition of an accepted level; target register updates on the next edge (DEBOUNCE_CYCLES+3 edges after a clean raw rise).
REQ-017 Increase event: target <= target+1; if target == DUTY_MAX, target holds and sat_flag pulses.
REQ-018 Decrease event: target <= target-1; if target == 0, target holds and sat_flag pulses.
REQ-019 Increase and decrease events in the same cycle SHALL both be discarded; target holds, no sat_flag.
REQ-020 FSM states: IDLE, PENDING, LOAD.
REQ-021 IDLE -> PENDING when target changes; IDLE otherwise.
REQ-022 PENDING -> LOAD on period_end; in that transition duty_cmd <= target value held before that edge.
REQ-023 LOAD: duty_load = 1 for exactly one cycle; LOAD -> PENDING if target != duty_cmd, else IDLE.
REQ-024 An event coinciding with period_end SHALL update target but not the value loaded; it is applied at the following period_end.
REQ-025 duty_cmd SHALL never change except on the edge entering LOAD (no mid-period glitch).
REQ-026 duty_pending SHALL equal (target != duty_cmd), registered.
REQ-027 period_end while in IDLE or LOAD SHALL have no effect.

Reset
REQ-028 rst_n low SHALL immediately force: duty_cmd = DUTY_INIT, target = DUTY_INIT, duty_load = 0, duty_pending = 0, sat_flag = 0, FSM = IDLE, synchronizers/debounce counters/accepted levels = 0.
REQ-029 Reset mid-PENDING SHALL discard the pending target; a button held through reset release SHALL generate one event after debounce.

Configuration
REQ-030 Macro PWM_DUTY_CTRL_AUTOREPEAT_EN defined: while an accepted level stays high, an additional event of the same direction SHALL fire every REPEAT_CYCLES cycles after the initial event, saturation rules unchanged.
REQ-031 Macro undefined: exactly one event per accepted press; repeat counter not synthesized.

Verification
REQ-032 Reset release, no buttons, period_end every 10 cycles -> duty_cmd = 5, duty_load never asserts, duty_pending = 0.
REQ-033 increase_duty high 100 ns (10 clk) -> target 6, duty_pending = 1, next period_end -> duty_cmd = 6 with one duty_load pulse, duty_pending = 0.
REQ-034 increase_duty pulse of 2 clk (bounce) -> no event, duty_cmd stays 5.
REQ-035 Seven clean increase presses within one period, then one period_end -> target saturates at 10, two sat_flag pulses, single duty_load to 10.
REQ-036 Both buttons rise together, held 10 clk -> target unchanged, no sat_flag; separately, event coincident with period_end -> old target loaded, new target loaded at next period_end.
REQ-037 With PWM_DUTY_CTRL_AUTOREPEAT_EN, decrease held 200 clk from duty 5 -> events at initial +0, +50, +100, +150 -> target 1; without macro -> target 4.
